// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: Tuse/Tnew codes and the stall-cause encoding.
package hazard_scoreboard_pkg;

    localparam logic [1:0] TUSE_NONE   = 2'b11;

    localparam logic [1:0] TNEW_LINK   = 2'd0;
    localparam logic [1:0] TNEW_ALU    = 2'd1;
    localparam logic [1:0] TNEW_LOAD   = 2'd2;

    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_DATA = 2'd1,
        CAUSE_MD   = 2'd2
    } stall_cause_e;

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Youngest-match lookup and forward mux for one decode source register (hazard_src_match).
module hazard_src_match #(
    parameter int STAGES = 3,
    parameter int REG_AW = 5,
    parameter int DATA_W = 32,
    parameter int TNEW_W = 2,
    parameter int SRC_W  = $clog2(STAGES + 1)
) (
    input  logic [REG_AW-1:0]              addr,
    input  logic [TNEW_W-1:0]              tuse,
    input  logic [STAGES-1:0]              ent_valid,
    input  logic [STAGES-1:0][REG_AW-1:0]  ent_dst,
    input  logic [STAGES-1:0][TNEW_W-1:0]  ent_tnew,
    input  logic [STAGES*DATA_W-1:0]       st_data,
    input  logic [DATA_W-1:0]              rf_data,
    output logic                           hazard,
    output logic                           pending,
    output logic [SRC_W-1:0]               fwd_src,
    output logic [DATA_W-1:0]              fwd_data
);

    logic              found;
    logic [TNEW_W-1:0] m_tnew;
    logic [SRC_W-1:0]  m_src;
    logic [DATA_W-1:0] m_data;
    logic              used;
    logic              ready;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        found  = 1'b0;
        m_tnew = '0;
        m_src  = '0;
        m_data = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (ent_valid[k] && (ent_dst[k] == addr) && (addr != '0)) begin
                found  = 1'b1;
                m_tnew = ent_tnew[k];
                m_src  = SRC_W'(k + 1);
                m_data = st_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        used     = (tuse != {TNEW_W{1'b1}});
        ready    = found && (m_tnew == '0);
        hazard   = found && used && (m_tnew > tuse);
        pending  = found && (m_tnew != '0) && (m_tnew <= tuse);
        fwd_src  = ready ? m_src : '0;
        fwd_data = ready ? m_data : rf_data;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight write table with Tnew countdown; produces decode stall and forwarding.
// Optional HAZARD_STATS_EN adds saturating data/mult-div stall counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_AW = 5,
    parameter int DATA_W = 32,
    parameter int TNEW_W = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           id_valid,
    input  logic [REG_AW-1:0]              id_rs_addr,
    input  logic [REG_AW-1:0]              id_rt_addr,
    input  logic [TNEW_W-1:0]              id_rs_tuse,
    input  logic [TNEW_W-1:0]              id_rt_tuse,
    input  logic                           id_dst_we,
    input  logic [REG_AW-1:0]              id_dst_addr,
    input  logic [TNEW_W-1:0]              id_tnew,
    input  logic                           id_is_md,
    input  logic                           md_busy,
    input  logic                           md_start_e,
    input  logic [DATA_W-1:0]              rf_rs_data,
    input  logic [DATA_W-1:0]              rf_rt_data,
    input  logic [STAGES*DATA_W-1:0]       st_data,
    output logic                           stall,
    output logic [DATA_W-1:0]              rs_data,
    output logic [DATA_W-1:0]              rt_data,
    output logic [$clog2(STAGES+1)-1:0]    rs_src,
    output logic [$clog2(STAGES+1)-1:0]    rt_src,
    output logic                           rs_pending,
    output logic                           rt_pending
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                    stat_data_stalls,
    output logic [31:0]                    stat_md_stalls
`endif
);

    localparam int SRC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]             ent_valid;
    logic [STAGES-1:0][REG_AW-1:0] ent_dst;
    logic [STAGES-1:0][TNEW_W-1:0] ent_tnew;

    logic         rs_hazard;
    logic         rt_hazard;
    logic         md_hazard;
    logic         push;
    stall_cause_e stall_cause;

    hazard_src_match #(
        .STAGES(STAGES), .REG_AW(REG_AW), .DATA_W(DATA_W), .TNEW_W(TNEW_W), .SRC_W(SRC_W)
    ) u_rs_match (
        .addr(id_rs_addr), .tuse(id_rs_tuse),
        .ent_valid(ent_valid), .ent_dst(ent_dst), .ent_tnew(ent_tnew),
        .st_data(st_data), .rf_data(rf_rs_data),
        .hazard(rs_hazard), .pending(rs_pending), .fwd_src(rs_src), .fwd_data(rs_data)
    );

    hazard_src_match #(
        .STAGES(STAGES), .REG_AW(REG_AW), .DATA_W(DATA_W), .TNEW_W(TNEW_W), .SRC_W(SRC_W)
    ) u_rt_match (
        .addr(id_rt_addr), .tuse(id_rt_tuse),
        .ent_valid(ent_valid), .ent_dst(ent_dst), .ent_tnew(ent_tnew),
        .st_data(st_data), .rf_data(rf_rt_data),
        .hazard(rt_hazard), .pending(rt_pending), .fwd_src(rt_src), .fwd_data(rt_data)
    );

    // Data hazards take precedence so the structural cause means "stalled only by mult/div".
    always_comb begin
        md_hazard   = id_is_md && (md_busy || md_start_e);
        stall_cause = CAUSE_NONE;
        if (id_valid && (rs_hazard || rt_hazard)) begin
            stall_cause = CAUSE_DATA;
        end else if (id_valid && md_hazard) begin
            stall_cause = CAUSE_MD;
        end
        stall = (stall_cause != CAUSE_NONE);
        push  = id_valid && !stall;
    end

    // A stalled or empty decode slot enters the table as a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid <= '0;
            ent_dst   <= '0;
            ent_tnew  <= '0;
        end else if (flush) begin
            ent_valid <= '0;
            ent_dst   <= '0;
            ent_tnew  <= '0;
        end else begin
            ent_valid[0] <= push && id_dst_we && (id_dst_addr != '0);
            ent_dst[0]   <= push ? id_dst_addr : '0;
            ent_tnew[0]  <= push ? id_tnew : '0;
            for (int k = 1; k < STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_dst[k]   <= ent_dst[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_data_stalls <= '0;
            stat_md_stalls   <= '0;
        end else begin
            if ((stall_cause == CAUSE_DATA) && (stat_data_stalls != '1)) begin
                stat_data_stalls <= stat_data_stalls + 32'd1;
            end
            if ((stall_cause == CAUSE_MD) && (stat_md_stalls != '1)) begin
                stat_md_stalls <= stat_md_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [1:0]  id_rs_tuse;
    logic [1:0]  id_rt_tuse;
    logic        id_dst_we;
    logic [4:0]  id_dst_addr;
    logic [1:0]  id_tnew;
    logic        id_is_md;
    logic        md_busy;
    logic        md_start_e;
    logic [31:0] rf_rs_data;
    logic [31:0] rf_rt_data;
    logic [95:0] st_data;
    logic        stall;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [1:0]  rs_src;
    logic [1:0]  rt_src;
    logic        rs_pending;
    logic        rt_pending;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_data_stalls;
    logic [31:0] stat_md_stalls;
`endif

    int checks;
    int errors;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse),
        .id_dst_we(id_dst_we), .id_dst_addr(id_dst_addr), .id_tnew(id_tnew),
        .id_is_md(id_is_md), .md_busy(md_busy), .md_start_e(md_start_e),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .st_data(st_data),
        .stall(stall), .rs_data(rs_data), .rt_data(rt_data),
        .rs_src(rs_src), .rt_src(rt_src),
        .rs_pending(rs_pending), .rt_pending(rt_pending)
`ifdef HAZARD_STATS_EN
        ,
        .stat_data_stalls(stat_data_stalls), .stat_md_stalls(stat_md_stalls)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        id_valid    = 1'b0;
        id_rs_addr  = 5'd0;
        id_rt_addr  = 5'd0;
        id_rs_tuse  = TUSE_NONE;
        id_rt_tuse  = TUSE_NONE;
        id_dst_we   = 1'b0;
        id_dst_addr = 5'd0;
        id_tnew     = 2'd0;
        id_is_md    = 1'b0;
        md_busy     = 1'b0;
        md_start_e  = 1'b0;
        st_data     = '0;
    endtask

    task automatic drive_writer(input logic [4:0] dst, input logic [1:0] tnew);
        idle_inputs();
        id_valid    = 1'b1;
        id_dst_we   = 1'b1;
        id_dst_addr = dst;
        id_tnew     = tnew;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        id_rs_addr = 5'd8;
        rf_rs_data = 32'h1234;
        rf_rt_data = 32'h5678;
        #2;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst = 1'b1;
        step();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b want 0", stall); end
        checks++;
        if (rs_src !== 2'd0) begin errors++; $display("FAIL idle_rs_src: got %0d want 0", rs_src); end
        checks++;
        if (rs_data !== 32'h1234) begin errors++; $display("FAIL idle_rs_data: got %h want 1234", rs_data); end
        checks++;
        if (rs_pending !== 1'b0) begin errors++; $display("FAIL idle_rs_pending: got %b want 0", rs_pending); end
    endtask

    task automatic test_load_use();
        drive_writer(5'd8, TNEW_LOAD);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lw_push_stall: got %b want 0", stall); end
        step();
        // add $11 <- $8 (tuse=1), rt=$11 with tuse=0 exposes a non-bubble entry 0
        drive_writer(5'd11, TNEW_ALU);
        id_rs_addr = 5'd8;  id_rs_tuse = TUSE_ALU;
        id_rt_addr = 5'd11; id_rt_tuse = TUSE_BRANCH;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall); end
        checks++;
        if (rs_pending !== 1'b0) begin errors++; $display("FAIL lu_pending_at_stall: got %b want 0", rs_pending); end
        step();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_release_stall: got %b want 0", stall); end
        checks++;
        if (rs_pending !== 1'b1) begin errors++; $display("FAIL lu_pending: got %b want 1", rs_pending); end
        checks++;
        if (rs_src !== 2'd0) begin errors++; $display("FAIL lu_pending_src: got %0d want 0", rs_src); end
        checks++;
        if (rs_data !== 32'h1234) begin errors++; $display("FAIL lu_pending_data: got %h want 1234", rs_data); end
        step();
        idle_inputs();
        id_valid   = 1'b1;
        id_rs_addr = 5'd8;  id_rs_tuse = TUSE_ALU;
        id_rt_addr = 5'd11; id_rt_tuse = TUSE_STORE;
        st_data[2*32 +: 32] = 32'hCAFE;
        #1;
        checks++;
        if (rs_src !== 2'd3) begin errors++; $display("FAIL lu_fwd_src: got %0d want 3", rs_src); end
        checks++;
        if (rs_data !== 32'hCAFE) begin errors++; $display("FAIL lu_fwd_data: got %h want cafe", rs_data); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_fwd_stall: got %b want 0", stall); end
        checks++;
        if (rt_pending !== 1'b1) begin errors++; $display("FAIL lu_rt_pending: got %b want 1", rt_pending); end
        checks++;
        if (rt_data !== 32'h5678) begin errors++; $display("FAIL lu_rt_data: got %h want 5678", rt_data); end
        drain();
    endtask

    task automatic test_branch();
        drive_writer(5'd9, TNEW_ALU);
        step();
        idle_inputs();
        id_valid   = 1'b1;
        id_rs_addr = 5'd9; id_rs_tuse = TUSE_BRANCH;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL br_stall: got %b want 1", stall); end
        step();
        st_data[1*32 +: 32] = 32'h55AA;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL br_release: got %b want 0", stall); end
        checks++;
        if (rs_src !== 2'd2) begin errors++; $display("FAIL br_src: got %0d want 2", rs_src); end
        checks++;
        if (rs_data !== 32'h55AA) begin errors++; $display("FAIL br_data: got %h want 55aa", rs_data); end
        drain();
    endtask

    task automatic test_youngest();
        drive_writer(5'd10, TNEW_LINK);
        step();
        drive_writer(5'd10, TNEW_LINK);
        step();
        idle_inputs();
        id_valid   = 1'b1;
        id_rs_addr = 5'd10; id_rs_tuse = TUSE_BRANCH;
        id_rt_addr = 5'd10; id_rt_tuse = TUSE_ALU;
        st_data[0*32 +: 32] = 32'h1;
        st_data[1*32 +: 32] = 32'h2;
        #1;
        checks++;
        if (rs_src !== 2'd1) begin errors++; $display("FAIL yg_rs_src: got %0d want 1", rs_src); end
        checks++;
        if (rs_data !== 32'h1) begin errors++; $display("FAIL yg_rs_data: got %h want 1", rs_data); end
        checks++;
        if (rt_src !== 2'd1) begin errors++; $display("FAIL yg_rt_src: got %0d want 1", rt_src); end
        checks++;
        if (rt_data !== 32'h1) begin errors++; $display("FAIL yg_rt_data: got %h want 1", rt_data); end
        drain();
    endtask

    task automatic test_zero_and_md();
        drive_writer(5'd0, TNEW_LOAD);
        step();
        idle_inputs();
        id_valid   = 1'b1;
        id_rs_addr = 5'd0; id_rs_tuse = TUSE_BRANCH;
        id_rt_addr = 5'd0; id_rt_tuse = TUSE_BRANCH;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", stall); end
        checks++;
        if (rs_src !== 2'd0) begin errors++; $display("FAIL zero_src: got %0d want 0", rs_src); end
        checks++;
        if (rs_data !== 32'h1234) begin errors++; $display("FAIL zero_data: got %h want 1234", rs_data); end
        idle_inputs();
        id_valid = 1'b1;
        id_is_md = 1'b1;
        md_busy  = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL md_busy_stall: got %b want 1", stall); end
        step();
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL md_busy_hold: got %b want 1", stall); end
        md_busy = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL md_release: got %b want 0", stall); end
        md_start_e = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL md_start_stall: got %b want 1", stall); end
        id_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL md_novalid: got %b want 0", stall); end
        drain();
    endtask

    task automatic test_flush_and_async_reset();
        drive_writer(5'd8, TNEW_LOAD);
        step();
        idle_inputs();
        id_valid   = 1'b1;
        id_rs_addr = 5'd8; id_rs_tuse = TUSE_ALU;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL fl_pre_stall: got %b want 1", stall); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b want 0", stall); end
        checks++;
        if (rs_pending !== 1'b0) begin errors++; $display("FAIL fl_pending: got %b want 0", rs_pending); end
        drain();
        drive_writer(5'd8, TNEW_LOAD);
        step();
        idle_inputs();
        id_valid   = 1'b1;
        id_rs_addr = 5'd8; id_rs_tuse = TUSE_ALU;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL ar_pre_stall: got %b want 1", stall); end
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL ar_stall: got %b want 0", stall); end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL ar_after_release: got %b want 0", stall); end
        drain();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        rf_rs_data = '0;
        rf_rt_data = '0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_youngest();
        test_zero_and_md();
        test_flush_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
